// File: rtl/pcie_tb_rst_ctrl.sv
// Test-harness reset/watchdog controller: staggered per-channel active-low resets,
// saturating cycle counter and kickable watchdog. Optional macro: PCIE_TB_RST_ORDERED_EN.
module pcie_tb_rst_ctrl #(
  parameter int unsigned NUM_RST        = 2,
  parameter int unsigned DLY_W          = 8,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned WD_W           = 24,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     Clk,
  input  logic                     notReset,
  input  logic [NUM_RST*DLY_W-1:0] RstRelDelay,
  input  logic                     WdEnable,
  input  logic                     WdKick,
  output logic [NUM_RST-1:0]       ChanReset,
  output logic                     AllOutOfReset,
  output logic [CNT_W-1:0]         CycleCount,
  output logic                     Timeout,
  output logic [1:0]               State
);

  typedef enum logic [1:0] {
    StReset     = 2'd0,
    StReleasing = 2'd1,
    StRun       = 2'd2,
    StTimeout   = 2'd3
  } state_e;

  localparam longint unsigned WdLimit    = (64'd1 << WD_W) - 64'd1;
  localparam logic [DLY_W-1:0] DlyMax    = '1;
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [WD_W-1:0]  WdMax     = '1;
  localparam logic [WD_W-1:0]  TimeoutVal = WD_W'(TIMEOUT_CYCLES);
  localparam bit               WdOn      = (TIMEOUT_CYCLES != 0);

  if (64'(TIMEOUT_CYCLES) > WdLimit) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in the WD_W-bit watchdog counter");
  end
  if (NUM_RST < 1 || NUM_RST > 16) begin : gen_bad_num_rst
    $error("NUM_RST must be in 1..16");
  end

  state_e                         state_q, state_d;
  logic [NUM_RST-1:0][DLY_W-1:0]  dly_q, dly_d;
  logic [NUM_RST-1:0][DLY_W-1:0]  dly_in, dly_cmp;
  logic [DLY_W-1:0]               rel_q, rel_d;
  logic [NUM_RST-1:0]             chan_q, chan_d;
  logic                           all_q, all_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic                           to_q, to_d;

  // Unpack the delay bus; in ordered mode each channel waits at least as long as its predecessor.
  always_comb begin
    logic [DLY_W-1:0] run_max;
    logic [DLY_W-1:0] cur;
    run_max = '0;
    dly_in  = '0;
    for (int i = 0; i < NUM_RST; i++) begin
      cur = RstRelDelay[i*DLY_W +: DLY_W];
      if (cur > run_max) run_max = cur;
`ifdef PCIE_TB_RST_ORDERED_EN
      dly_in[i] = run_max;
`else
      dly_in[i] = cur;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    dly_cmp = dly_q;
    rel_d   = rel_q;
    chan_d  = chan_q;
    all_d   = all_q;
    wd_d    = wd_q;
    to_d    = to_q;
    cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      StReset: begin
        // First edge out of reset: capture delays and compare against them immediately.
        dly_d   = dly_in;
        dly_cmp = dly_in;
        rel_d   = '0;
        state_d = StReleasing;
      end
      StReleasing: begin
        if (rel_q != DlyMax) rel_d = rel_q + DLY_W'(1);
        if (&chan_q) begin
          state_d = StRun;
          all_d   = 1'b1;
        end
      end
      StRun: begin
        if (WdKick) begin
          wd_d = '0;
        end else if (WdEnable && wd_q != WdMax) begin
          wd_d = wd_q + WD_W'(1);
        end
        if (WdOn && wd_d == TimeoutVal) begin
          to_d    = 1'b1;
          state_d = StTimeout;
        end
      end
      StTimeout: begin
        state_d = StTimeout;
      end
    endcase

    if (state_q == StReset || state_q == StReleasing) begin
      for (int i = 0; i < NUM_RST; i++) begin
        if (rel_d == dly_cmp[i]) chan_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= StReset;
      dly_q   <= '0;
      rel_q   <= '0;
      chan_q  <= '0;
      all_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rel_q   <= rel_d;
      chan_q  <= chan_d;
      all_q   <= all_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign ChanReset     = chan_q;
  assign AllOutOfReset = all_q;
  assign CycleCount    = cnt_q;
  assign Timeout       = to_q;
  assign State         = state_q;

endmodule

// File: tb/tb_pcie_tb_rst_ctrl.sv
// Randomized bench for pcie_tb_rst_ctrl against an edge-count based reference model.
module tb_pcie_tb_rst_ctrl;

  localparam int unsigned NumRst = 3;
  localparam int unsigned DlyW   = 5;
  localparam int unsigned CntW   = 6;
  localparam int unsigned WdW    = 8;
  localparam int unsigned ToCyc  = 20;
  localparam int unsigned DW     = NumRst * DlyW;
  localparam int          CntMax = (1 << CntW) - 1;
  localparam int          DlyMsk = (1 << DlyW) - 1;
  localparam int          WdMax  = (1 << WdW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     rst_rel_delay = '0;
  logic              wd_en = 1'b0;
  logic              wd_kick = 1'b0;
  logic [NumRst-1:0] chan_rst;
  logic              all_out;
  logic [CntW-1:0]   cyc_cnt;
  logic              timeout;
  logic [1:0]        state;

  pcie_tb_rst_ctrl #(
    .NUM_RST       (NumRst),
    .DLY_W         (DlyW),
    .CNT_W         (CntW),
    .WD_W          (WdW),
    .TIMEOUT_CYCLES(ToCyc)
  ) dut (
    .Clk          (clk),
    .notReset     (rst_n),
    .RstRelDelay  (rst_rel_delay),
    .WdEnable     (wd_en),
    .WdKick       (wd_kick),
    .ChanReset    (chan_rst),
    .AllOutOfReset(all_out),
    .CycleCount   (cyc_cnt),
    .Timeout      (timeout),
    .State        (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: n = edges since reset release, eff = effective delays captured at E1.
  int n = 0;
  int eff[NumRst];
  int wd = 0;
  bit timed_out = 1'b0;
  int mode = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  function automatic int rel_edge();
    int m = 0;
    for (int i = 0; i < NumRst; i++) if (eff[i] > m) m = eff[i];
    return 2 + m;
  endfunction

  task automatic capture_delays();
    int d;
    for (int i = 0; i < NumRst; i++) begin
      d = int'((rst_rel_delay >> (i * DlyW))) & DlyMsk;
`ifdef PCIE_TB_RST_ORDERED_EN
      if (i > 0 && eff[i-1] > d) d = eff[i-1];
`endif
      eff[i] = d;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [NumRst-1:0] e_chan;
    int r;
    int e_state;
    r = rel_edge();
    for (int i = 0; i < NumRst; i++) e_chan[i] = (n >= 1) && (n >= 1 + eff[i]);
    if (n == 0) e_state = 0;
    else if (n < r) e_state = 1;
    else if (timed_out) e_state = 3;
    else e_state = 2;
    check_val({ctx, ".chan"}, 64'(chan_rst), 64'(e_chan));
    check_val({ctx, ".all"}, 64'(all_out), 64'((n >= 1 && n >= r) ? 1 : 0));
    check_val({ctx, ".cnt"}, 64'(cyc_cnt), 64'((n > CntMax) ? CntMax : n));
    check_val({ctx, ".timeout"}, 64'(timeout), 64'(timed_out));
    check_val({ctx, ".state"}, 64'(state), 64'(e_state));
  endtask

  // Drive inputs for the coming edge, take the edge, advance the model, then sample.
  task automatic step();
    if (n >= 1) rst_rel_delay = DW'($urandom);
    case (mode)
      0: begin
        wd_en   = ($urandom_range(3, 0) != 0);
        wd_kick = ($urandom_range(15, 0) == 0);
      end
      1: begin
        wd_en   = 1'b1;
        wd_kick = 1'b0;
      end
      default: begin
        wd_en   = 1'b1;
        wd_kick = (wd == ToCyc - 1) || (wd == 14 && $urandom_range(1, 0) == 1);
      end
    endcase
    @(posedge clk);
    n++;
    if (n == 1) capture_delays();
    if (n - 1 >= rel_edge() && n >= 2 && !timed_out) begin
      if (wd_kick) wd = 0;
      else if (wd_en && wd < WdMax) wd++;
      if (ToCyc != 0 && wd == ToCyc) timed_out = 1'b1;
    end
    #1;
    check_all("run");
  endtask

  task automatic model_reset();
    n = 0;
    wd = 0;
    timed_out = 1'b0;
    for (int i = 0; i < NumRst; i++) eff[i] = 0;
  endtask

  // Called just after a sample point; reset pulse is 3 ns and ends before the next edge.
  task automatic async_reset(input logic [DW-1:0] new_dly);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    rst_rel_delay = new_dly;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #13;
    check_all("por");
    rst_rel_delay = {5'd5, 5'd2, 5'd10};
    rst_n = 1'b1;

    // Directed delays {10,2,5} with an unkicked watchdog running to expiry.
    mode = 1;
    for (int k = 0; k < 50; k++) step();

    // Reset in mid-release after channel 1 is out, then restart with new delays.
    async_reset({5'd5, 5'd2, 5'd10});
    mode = 2;
    for (int k = 0; k < 5; k++) step();
    async_reset({5'd1, 5'd7, 5'd3});
    for (int k = 0; k < 70; k++) step();

    // Equal and maximum delays.
    async_reset({5'd31, 5'd4, 5'd4});
    mode = 0;
    for (int k = 0; k < 80; k++) step();
    async_reset({5'd0, 5'd0, 5'd0});
    mode = 1;
    for (int k = 0; k < 30; k++) step();

    for (int run = 0; run < 8; run++) begin
      async_reset(DW'($urandom));
      mode = int'($urandom_range(2, 0));
      for (int k = 0; k < 75; k++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tb_rst_ctrl.md
Name: pcie_tb_rst_ctrl

Overview:
- Parametrised test-harness control block for pcieVHost simulations.
- Replaces the fixed single-reset "count > 10" scheme and free-running timeout counter.
- Produces NUM_RST independently delayed active-low channel resets (host, endpoint, displays, ...), a saturating cycle counter, and a kickable watchdog with a sticky timeout flag.
- Sits at the top of a test bench; its outputs drive the notReset of each VHost/display instance.

Parameters:
NUM_RST, 2, number of reset channels (1..16)
DLY_W, 8, width of each per-channel release delay field
CNT_W, 32, width of CycleCount
WD_W, 24, width of watchdog counter
TIMEOUT_CYCLES, 100000, watchdog limit in run cycles; 0 disables watchdog

Ports:
Clk  input  1  bench clock, rising-edge active
notReset  input  1  master reset, asynchronous, active-low
RstRelDelay  input  NUM_RST*DLY_W  per-channel release delay in cycles; channel i at [i*DLY_W +: DLY_W]
WdEnable  input  1  watchdog counts only when high
WdKick  input  1  clears watchdog count
ChanReset  output  NUM_RST  per-channel active-low resets
AllOutOfReset  output  1  all channels released
CycleCount  output  CNT_W  cycles since master reset release, saturating
Timeout  output  1  sticky watchdog expiry
State  output  2  FSM state: 0 RESET, 1 RELEASING, 2 RUN, 3 TIMEOUT

Behaviour:
- Clock and reset: one clock Clk; notReset is asynchronous, active-low.
- Reset values while notReset low: ChanReset=0, AllOutOfReset=0, CycleCount=0, Timeout=0, State=RESET, internal counters=0.
- Edge numbering: E1 is the first Clk rising edge with notReset high; En is the n-th such edge.
- FSM:
  - RESET -> RELEASING at E1.
  - RELEASING -> RUN on the edge after the last channel is released.
  - RUN -> TIMEOUT on watchdog expiry.
  - TIMEOUT is terminal until notReset is asserted.
- Delay sampling: RstRelDelay is captured into internal registers at E1. Later changes are ignored until the next reset.
- Release counter RelCount:
  - 0 after E1; increments each edge in RELEASING.
  - Saturates at 2^DLY_W-1.
- Channel release: ChanReset[i] goes high after edge E(1+delay_i) and stays high until reset. Delay 0 releases after E1.
  - Implementation: ChanReset[i] set when RelCount == captured delay_i, including at E1.
- AllOutOfReset and State=RUN go high together after E(2+max delay).
- CycleCount:
  - Increments on every edge from E1 onwards, in all non-RESET states.
  - Holds at all-ones on saturation; no wrap.
- Watchdog, active in RUN only:
  - WdKick high: count <= 0. Kick wins over increment.
  - Else, if WdEnable high: count increments.
  - When the count reaches TIMEOUT_CYCLES, Timeout <= 1 and State <= TIMEOUT on the same edge.
  - Count saturates at 2^WD_W-1.
  - TIMEOUT_CYCLES=0: watchdog never fires.
  - TIMEOUT_CYCLES > 2^WD_W-1 is an elaboration error ($error).
- In TIMEOUT:
  - ChanReset and AllOutOfReset hold their values; CycleCount keeps counting.
  - The bench calls its Fatal task on Timeout rising.
- Reset mid-operation: asserting notReset in any state asynchronously returns all outputs to reset values within the same timestep. Channel delays are re-captured on the next E1.
- Simultaneous events:
  - Kick on the expiry edge: the kick wins and no timeout occurs.
  - Equal delays: those channels release on the same edge.

Optional Feature:
- Macro: PCIE_TB_RST_ORDERED_EN.
- Defined: ordered release. Channel i may not release before channel i-1.
  - Effective delay_i = max(delay_i, effective delay_(i-1)).
  - Equal effective delays release together.
- Undefined: channels release independently per their own delays.

Test Plan:
- NUM_RST=3, delays {ch0=10, ch1=2, ch2=5}, notReset released at t0 -> ChanReset[1] high after E3, [2] after E6, [0] after E11; AllOutOfReset and State=2 after E12.
- Same delays with PCIE_TB_RST_ORDERED_EN defined -> ch0 after E11; ch1 and ch2 also after E11; AllOutOfReset after E12.
- TIMEOUT_CYCLES=20, WdEnable=1, no kick -> Timeout=1 and State=3 on the 20th RUN edge; CycleCount keeps counting.
- TIMEOUT_CYCLES=20, kick every 15 RUN cycles for 200 cycles, including one kick on the would-be expiry edge -> Timeout stays 0.
- Assert notReset low for 3 ns mid-RELEASING, after ch1 is released -> all outputs 0 immediately; after release the sequence restarts from E1 with the new RstRelDelay values.
- CNT_W=4, run 20 cycles -> CycleCount reaches 15 and holds at 15.
